// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/debug arbiter for the shared instruction/data memory.
// Define ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
module mem_port_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  state_t     state, state_nxt;
  logic       gnt;
  logic       lat_we;
  logic [2:0] lat_cnt;
  logic       win_dbg;
  logic       any_req;

  assign any_req = cpu_req | dbg_req;

`ifdef ARB_RR_EN
  // last = 1 means the CPU was served most recently, so a tie goes to debug
  logic last;

  always_comb begin
    win_dbg = ~cpu_req;
    if (cpu_req && dbg_req) win_dbg = last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last <= ~win_dbg;
    end
  end
`else
  always_comb win_dbg = ~cpu_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (lat_cnt == 3'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are frozen at the grant edge; later requester changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= 1'b0;
      lat_we    <= 1'b0;
      lat_cnt   <= 3'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt       <= win_dbg;
            lat_cnt   <= LAT_INIT;
            lat_we    <= win_dbg ? dbg_we    : cpu_we;
            mem_addr  <= win_dbg ? dbg_addr  : cpu_addr;
            mem_wdata <= win_dbg ? dbg_wdata : cpu_wdata;
          end
        end
        ACCESS: begin
          if (lat_cnt != 3'd0) begin
            lat_cnt <= lat_cnt - 3'd1;
          end else if (!lat_we) begin
            if (gnt) dbg_rdata <= mem_rdata;
            else     cpu_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobe only in the first ACCESS cycle, identified by the untouched counter
  assign mem_we    = (state == ACCESS) && lat_we && (lat_cnt == LAT_INIT);
  assign cpu_ack   = (state == DONE) && !gnt;
  assign dbg_ack   = (state == DONE) && gnt;
  assign busy      = (state != IDLE);
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter at MEM_LAT 1 and 3.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [31:0] sb[$];

  logic        cpu_req_1 = 0, cpu_we_1 = 0, dbg_req_1 = 0, dbg_we_1 = 0;
  logic [7:0]  cpu_addr_1 = 0, dbg_addr_1 = 0;
  logic [31:0] cpu_wdata_1 = 0, dbg_wdata_1 = 0;
  logic [31:0] cpu_rdata_1, dbg_rdata_1, mem_wdata_1, mem_rdata_1;
  logic        cpu_ack_1, cpu_stall_1, dbg_ack_1, mem_we_1, busy_1;
  logic [7:0]  mem_addr_1;

  logic        cpu_req_3 = 0, cpu_we_3 = 0, dbg_req_3 = 0, dbg_we_3 = 0;
  logic [7:0]  cpu_addr_3 = 0, dbg_addr_3 = 0;
  logic [31:0] cpu_wdata_3 = 0, dbg_wdata_3 = 0;
  logic [31:0] cpu_rdata_3, dbg_rdata_3, mem_wdata_3, mem_rdata_3;
  logic        cpu_ack_3, cpu_stall_3, dbg_ack_3, mem_we_3, busy_3;
  logic [7:0]  mem_addr_3;

  mem_port_arbiter #(.AW(8), .DW(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req_1), .cpu_we(cpu_we_1), .cpu_addr(cpu_addr_1), .cpu_wdata(cpu_wdata_1),
    .cpu_rdata(cpu_rdata_1), .cpu_ack(cpu_ack_1), .cpu_stall(cpu_stall_1),
    .dbg_req(dbg_req_1), .dbg_we(dbg_we_1), .dbg_addr(dbg_addr_1), .dbg_wdata(dbg_wdata_1),
    .dbg_rdata(dbg_rdata_1), .dbg_ack(dbg_ack_1),
    .mem_addr(mem_addr_1), .mem_we(mem_we_1), .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1),
    .busy(busy_1)
  );

  mem_port_arbiter #(.AW(8), .DW(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req_3), .cpu_we(cpu_we_3), .cpu_addr(cpu_addr_3), .cpu_wdata(cpu_wdata_3),
    .cpu_rdata(cpu_rdata_3), .cpu_ack(cpu_ack_3), .cpu_stall(cpu_stall_3),
    .dbg_req(dbg_req_3), .dbg_we(dbg_we_3), .dbg_addr(dbg_addr_3), .dbg_wdata(dbg_wdata_3),
    .dbg_rdata(dbg_rdata_3), .dbg_ack(dbg_ack_3),
    .mem_addr(mem_addr_3), .mem_we(mem_we_3), .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3),
    .busy(busy_3)
  );

  function automatic logic [31:0] pat(input logic [7:0] a);
    if (a == 8'h04) return 32'h8C010000;
    return {24'hA5A5A5, a};
  endfunction

  // Memory models: latency 1 reads combinationally, latency 3 through a 2-stage address pipe
  logic [31:0] mem_1 [256];
  logic [31:0] mem_3 [256];
  logic [7:0]  apipe_3 [2];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        mem_1[i] <= pat(8'(i));
        mem_3[i] <= pat(8'(i));
      end
      apipe_3[0] <= 8'h00;
      apipe_3[1] <= 8'h00;
    end else begin
      if (mem_we_1) mem_1[mem_addr_1] <= mem_wdata_1;
      if (mem_we_3) mem_3[mem_addr_3] <= mem_wdata_3;
      apipe_3[0] <= mem_addr_3;
      apipe_3[1] <= apipe_3[0];
    end
  end

  assign mem_rdata_1 = mem_1[mem_addr_1];
  assign mem_rdata_3 = mem_3[apipe_3[1]];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic run1(input bit dbg, input bit we, input logic [7:0] addr, input logic [31:0] wd,
                      output int ack_cyc, output int stalls, output int we_cyc,
                      output logic [7:0] we_addr, output logic [31:0] rd);
    ack_cyc = -1; stalls = 0; we_cyc = 0; we_addr = 8'h00; rd = 32'h0;
    @(posedge clk); #1;
    if (dbg) begin
      dbg_req_1 = 1; dbg_we_1 = we; dbg_addr_1 = addr; dbg_wdata_1 = wd;
    end else begin
      cpu_req_1 = 1; cpu_we_1 = we; cpu_addr_1 = addr; cpu_wdata_1 = wd;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (cpu_stall_1) stalls++;
      if (mem_we_1) begin we_cyc++; we_addr = mem_addr_1; end
      if (dbg ? dbg_ack_1 : cpu_ack_1) begin
        ack_cyc = k;
        rd = dbg ? dbg_rdata_1 : cpu_rdata_1;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_req_1 = 0; dbg_req_1 = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy_1, cpu_ack_1, dbg_ack_1, mem_we_1, cpu_stall_1, mem_addr_1, mem_wdata_1, cpu_rdata_1, dbg_rdata_1} !== '0)
      $display("FAIL reset_dut1: outputs not zero busy=%b ack=%b/%b we=%b addr=%h", busy_1, cpu_ack_1, dbg_ack_1, mem_we_1, mem_addr_1);
    else passed++;
    checks++;
    if ({busy_3, cpu_ack_3, dbg_ack_3, mem_we_3, cpu_stall_3, mem_addr_3, mem_wdata_3, cpu_rdata_3, dbg_rdata_3} !== '0)
      $display("FAIL reset_dut3: outputs not zero busy=%b ack=%b/%b we=%b addr=%h", busy_3, cpu_ack_3, dbg_ack_3, mem_we_3, mem_addr_3);
    else passed++;
    rst = 0;
  endtask

  task automatic test_cpu_read();
    int ack_cyc, stalls, we_cyc; logic [7:0] wa; logic [31:0] rd, exp;
    sb.push_back(pat(8'h04));
    run1(0, 0, 8'h04, 32'h0, ack_cyc, stalls, we_cyc, wa, rd);
    exp = sb.pop_front();
    checks++; if (ack_cyc != 3) $display("FAIL cpu_read_latency: got %0d want 3", ack_cyc); else passed++;
    checks++; if (stalls != 2) $display("FAIL cpu_read_stall: got %0d want 2", stalls); else passed++;
    checks++; if (rd !== exp) $display("FAIL cpu_read_data: got %h want %h", rd, exp); else passed++;
  endtask

  task automatic test_debug_write();
    int ack_cyc, stalls, we_cyc; logic [7:0] wa; logic [31:0] rd, exp;
    run1(1, 1, 8'h10, 32'hDEADBEEF, ack_cyc, stalls, we_cyc, wa, rd);
    checks++; if (we_cyc != 1) $display("FAIL dbg_write_we_cycles: got %0d want 1", we_cyc); else passed++;
    checks++; if (wa !== 8'h10) $display("FAIL dbg_write_addr: got %h want 10", wa); else passed++;
    checks++; if (ack_cyc != 3) $display("FAIL dbg_write_ack: got %0d want 3", ack_cyc); else passed++;
    sb.push_back(32'hDEADBEEF);
    run1(0, 0, 8'h10, 32'h0, ack_cyc, stalls, we_cyc, wa, rd);
    exp = sb.pop_front();
    checks++; if (rd !== exp) $display("FAIL cpu_readback: got %h want %h", rd, exp); else passed++;
    sb.push_back(pat(8'h20));
    run1(1, 0, 8'h20, 32'h0, ack_cyc, stalls, we_cyc, wa, rd);
    exp = sb.pop_front();
    checks++; if (rd !== exp) $display("FAIL dbg_read_data: got %h want %h", rd, exp); else passed++;
    checks++; if (cpu_rdata_1 !== 32'hDEADBEEF) $display("FAIL cpu_rdata_hold: got %h want deadbeef", cpu_rdata_1); else passed++;
  endtask

  task automatic test_contention();
    int exp_who[$]; int idx; int who; int got; int cpu_extra;
`ifdef ARB_RR_EN
    exp_who = '{1, 0, 1, 0};
`else
    exp_who = '{0, 0, 0, 0};
`endif
    @(posedge clk); #1;
    cpu_req_1 = 1; cpu_we_1 = 0; cpu_addr_1 = 8'h04;
    dbg_req_1 = 1; dbg_we_1 = 0; dbg_addr_1 = 8'h20;
    idx = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (cpu_ack_1 || dbg_ack_1) begin
        idx++;
        who = (exp_who.size() > 0) ? exp_who.pop_front() : 2;
        checks++;
        if ({dbg_ack_1, cpu_ack_1} !== ((who == 1) ? 2'b10 : (who == 0) ? 2'b01 : 2'b00))
          $display("FAIL contention_winner_%0d: got dbg/cpu=%b%b want who=%0d", idx, dbg_ack_1, cpu_ack_1, who);
        else passed++;
        checks++;
        if (k != 3 * idx) $display("FAIL contention_cycle_%0d: got %0d want %0d", idx, k, 3 * idx);
        else passed++;
      end
    end
    checks++;
    if (exp_who.size() != 0) $display("FAIL contention_count: %0d acks missing", exp_who.size());
    else passed++;
    @(posedge clk); #1;
    cpu_req_1 = 0;
    got = -1; cpu_extra = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (cpu_ack_1) cpu_extra++;
      if (dbg_ack_1) begin got = k; break; end
    end
    checks++; if (got != 3) $display("FAIL dbg_after_drop: got %0d want 3", got); else passed++;
    checks++; if (cpu_extra != 0) $display("FAIL cpu_ack_after_drop: got %0d want 0", cpu_extra); else passed++;
    checks++; if (dbg_rdata_1 !== pat(8'h20)) $display("FAIL dbg_drop_data: got %h want %h", dbg_rdata_1, pat(8'h20)); else passed++;
    @(posedge clk); #1;
    dbg_req_1 = 0;
  endtask

  task automatic test_latency3();
    int got; int we_cyc; logic [31:0] rd, exp;
    @(posedge clk); #1;
    cpu_req_3 = 1; cpu_we_3 = 0; cpu_addr_3 = 8'h30;
    sb.push_back(pat(8'h30));
    got = -1; rd = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy_3 && !cpu_ack_3) begin
        checks++;
        if (mem_addr_3 !== 8'h30) $display("FAIL lat3_addr_hold_c%0d: got %h want 30", k, mem_addr_3);
        else passed++;
      end
      if (cpu_ack_3) begin got = k; rd = cpu_rdata_3; break; end
      if (k == 2) begin
        @(posedge clk); #1;
        cpu_addr_3 = 8'h31;
      end
    end
    exp = sb.pop_front();
    checks++; if (got != 5) $display("FAIL lat3_latency: got %0d want 5", got); else passed++;
    checks++; if (rd !== exp) $display("FAIL lat3_data: got %h want %h", rd, exp); else passed++;
    @(posedge clk); #1;
    cpu_req_3 = 0;
    @(posedge clk); #1;
    dbg_req_3 = 1; dbg_we_3 = 1; dbg_addr_3 = 8'h40; dbg_wdata_3 = 32'hAA55AA55;
    got = -1; we_cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_we_3) we_cyc++;
      if (dbg_ack_3) begin got = k; break; end
    end
    checks++; if (we_cyc != 1) $display("FAIL lat3_write_we: got %0d want 1", we_cyc); else passed++;
    checks++; if (got != 5) $display("FAIL lat3_write_ack: got %0d want 5", got); else passed++;
    @(posedge clk); #1;
    dbg_req_3 = 0;
  endtask

  task automatic test_mid_reset();
    int got; logic [31:0] rd, exp;
    @(posedge clk); #1;
    cpu_req_3 = 1; cpu_we_3 = 0; cpu_addr_3 = 8'h30;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1;
    #1;
    checks++; if (busy_3 !== 1'b0) $display("FAIL mid_reset_idle: busy got %b want 0", busy_3); else passed++;
    checks++; if (cpu_rdata_3 !== 32'h0) $display("FAIL mid_reset_rdata3: got %h want 0", cpu_rdata_3); else passed++;
    checks++; if (cpu_rdata_1 !== 32'h0) $display("FAIL mid_reset_rdata1: got %h want 0", cpu_rdata_1); else passed++;
    @(negedge clk);
    checks++; if (cpu_ack_3 !== 1'b0) $display("FAIL mid_reset_no_ack: got %b want 0", cpu_ack_3); else passed++;
    @(posedge clk); #1;
    rst = 0;
    sb.push_back(pat(8'h30));
    got = -1; rd = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (cpu_ack_3) begin got = k; rd = cpu_rdata_3; break; end
    end
    exp = sb.pop_front();
    checks++; if (got != 5) $display("FAIL mid_reset_restart: got %0d want 5", got); else passed++;
    checks++; if (rd !== exp) $display("FAIL mid_reset_data: got %h want %h", rd, exp); else passed++;
    @(posedge clk); #1;
    cpu_req_3 = 0;
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_debug_write();
    test_contention();
    test_latency3();
    test_mid_reset();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters: the multi-cycle CPU datapath and a debug/program-loader port.
- Sits between the CPU address mux (PC/4 or ALUout/4) and the memory instance.
- Sequences each access through a small FSM and holds the CPU with a stall signal until its access completes.
- Fixed CPU priority by default; round-robin is available as a compile option.

Parameters:
- AW, 8, word-address width into memory.
- DW, 32, data width.
- MEM_LAT, 1, memory read latency in cycles (1..7): rdata is valid MEM_LAT cycles after the address is presented.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  CPU write enable (1 = write, 0 = read).
- cpu_addr  in  AW  CPU word address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  CPU read data, valid in the cpu_ack cycle.
- cpu_ack  out  1  one-cycle completion pulse to CPU.
- cpu_stall  out  1  equals cpu_req & ~cpu_ack (combinational); freezes the CPU FSM.
- dbg_req  in  1  debug request; held high until dbg_ack.
- dbg_we  in  1  debug write enable.
- dbg_addr  in  AW  debug word address.
- dbg_wdata  in  DW  debug write data.
- dbg_rdata  out  DW  debug read data, valid in the dbg_ack cycle.
- dbg_ack  out  1  one-cycle completion pulse to debug.
- mem_addr  out  AW  memory address.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- FSM states: IDLE, ACCESS, DONE. Register gnt selects the winning requester (0 = CPU, 1 = debug).
- Reset (asynchronous): state = IDLE, gnt = 0, lat_cnt = 0, all acks 0, mem_we 0, mem_addr 0, mem_wdata 0, both rdata registers 0, busy 0.
- IDLE:
  - If any req is high, latch the winner into gnt and latch its addr, we and wdata into internal registers.
  - Load lat_cnt = MEM_LAT - 1 and go to ACCESS.
  - With no req, stay in IDLE.
- Arbitration (default): CPU wins whenever cpu_req is high.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched registers for the whole state.
  - mem_we is high only in the first ACCESS cycle, and only if the latched we = 1.
  - lat_cnt decrements each cycle. When lat_cnt == 0, go to DONE and capture mem_rdata into the granted requester's rdata register. Writes also wait the full MEM_LAT.
- DONE:
  - Pulse the granted requester's ack for exactly one cycle.
  - Return to IDLE. No back-to-back grant from DONE.
- Latency: a request first seen high in IDLE at edge N produces ack in cycle N + MEM_LAT + 1. Throughput is one access per MEM_LAT + 2 cycles.
- rdata registers hold their value until the next read completes for the same requester.
- A non-granted requester's ack stays 0. Its req may stay high indefinitely and is served at the next IDLE.
- Request changes:
  - Dropping req, or changing addr/we/wdata, after the IDLE grant edge has no effect; the latched values are used.
  - A req that drops before IDLE samples it is ignored.
- Reset asserted mid-access: immediate return to reset values. No ack is issued for the aborted access. A write already strobed is not undone.
- Illegal state encoding: returns to IDLE.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last register (reset 1) records the requester most recently served.
  - When both reqs are high in IDLE, grant goes to the requester that is not last. Last updates at each grant.
  - A single requester is always granted.
- Undefined: fixed CPU priority as described in Behaviour; the last register is not implemented.

Test Plan:
- Reset, MEM_LAT=1: after rst pulse all outputs 0 and state IDLE. cpu_req read at addr 0x04, mem word 0x8C010000 → cpu_ack in the 3rd cycle after the req edge; cpu_rdata = 0x8C010000; cpu_stall high for 2 cycles.
- Debug write: addr 0x10, wdata 0xDEADBEEF → mem_we high exactly 1 cycle with mem_addr 0x10. dbg_ack follows. A subsequent CPU read of 0x10 returns 0xDEADBEEF.
- Contention, default build: cpu_req and dbg_req both high continuously → CPU acked every 3 cycles, debug never acked while cpu_req stays high. Dropping cpu_req → debug served next.
- Contention, ARB_RR_EN defined: both held high → ack order debug, CPU, debug, CPU (last resets to 1, so the CPU is treated as last served and the first grant goes to debug).
- MEM_LAT=3, CPU read: ack at cycle N+4. The CPU changing addr during ACCESS does not change mem_addr.
- rst asserted in the 2nd ACCESS cycle → state IDLE immediately, no cpu_ack. After rst drops, the held cpu_req restarts the access and completes normally.
